bf16_add_pipe: RTL and testbench



---
 rtl/bf16_add_pipe.sv | 187 ++++++++++++++++++
 tb/tb_bf16_add_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_add_pipe.sv
// Three-stage pipelined bfloat16 adder/subtractor with a valid/ready handshake.
// Stage 1 classifies and aligns, stage 2 adds magnitudes, stage 3 normalizes,
// rounds and selects special results. A single global stall holds all stages.
module bf16_add_pipe (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        sub_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] result_o
);

  logic advance;
  assign advance    = !out_valid_o || out_ready_i;
  assign in_ready_o = advance;

  // Stage 1 combinational: unpack, classify, order by magnitude, align.
  logic       sb_eff;
  logic [7:0] ea, eb, el, es, diff;
  logic [6:0] ma, mb, ml, ms;
  logic       a_nan, b_nan, a_inf, b_inf, a_big, sl, ss;
  logic [10:0] sig_l, sig_s_full, sig_s_al, lost;

  assign sb_eff = b_i[15] ^ sub_i;
  assign ea     = a_i[14:7];
  assign eb     = b_i[14:7];
  // Subnormals flush to zero but keep their sign.
  assign ma     = (ea == 8'd0) ? 7'd0 : a_i[6:0];
  assign mb     = (eb == 8'd0) ? 7'd0 : b_i[6:0];
  assign a_nan  = (ea == 8'hFF) && (a_i[6:0] != 7'd0);
  assign b_nan  = (eb == 8'hFF) && (b_i[6:0] != 7'd0);
  assign a_inf  = (ea == 8'hFF) && (a_i[6:0] == 7'd0);
  assign b_inf  = (eb == 8'hFF) && (b_i[6:0] == 7'd0);
  assign a_big  = {ea, ma} >= {eb, mb};
  assign sl     = a_big ? a_i[15] : sb_eff;
  assign ss     = a_big ? sb_eff : a_i[15];
  assign el     = a_big ? ea : eb;
  assign es     = a_big ? eb : ea;
  assign ml     = a_big ? ma : mb;
  assign ms     = a_big ? mb : ma;
  assign diff   = el - es;
  assign sig_l      = {el != 8'd0, ml, 3'b000};
  assign sig_s_full = {es != 8'd0, ms, 3'b000};

  // Right-shift the smaller significand; shifted-out ones fold into sticky.
  always_comb begin
    sig_s_al = 11'd0;
    lost     = 11'd0;
    if (diff >= 8'd11) begin
      sig_s_al = {10'd0, |sig_s_full};
    end else begin
      sig_s_al    = sig_s_full >> diff;
      lost        = sig_s_full & ~(11'h7FF << diff);
      sig_s_al[0] = sig_s_al[0] | (|lost);
    end
  end

  logic        s1_valid_q, s1_sign_l_q, s1_sign_s_q;
  logic [7:0]  s1_exp_q;
  logic [10:0] s1_sig_l_q, s1_sig_s_q;
  logic        s1_nan_q, s1_inf_q, s1_inf_sign_q, s1_zero_both_q, s1_zero_sign_q;

  // Stage 1 register: aligned operands plus special-case flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q     <= 1'b0;
      s1_sign_l_q    <= 1'b0;
      s1_sign_s_q    <= 1'b0;
      s1_exp_q       <= 8'd0;
      s1_sig_l_q     <= 11'd0;
      s1_sig_s_q     <= 11'd0;
      s1_nan_q       <= 1'b0;
      s1_inf_q       <= 1'b0;
      s1_inf_sign_q  <= 1'b0;
      s1_zero_both_q <= 1'b0;
      s1_zero_sign_q <= 1'b0;
    end else if (advance) begin
      s1_valid_q     <= in_valid_i;
      s1_sign_l_q    <= sl;
      s1_sign_s_q    <= ss;
      s1_exp_q       <= el;
      s1_sig_l_q     <= sig_l;
      s1_sig_s_q     <= sig_s_al;
      s1_nan_q       <= a_nan || b_nan || (a_inf && b_inf && (a_i[15] != sb_eff));
      s1_inf_q       <= a_inf || b_inf;
      s1_inf_sign_q  <= a_inf ? a_i[15] : sb_eff;
      s1_zero_both_q <= (ea == 8'd0) && (eb == 8'd0);
      s1_zero_sign_q <= a_i[15] & sb_eff;
    end
  end

  // Stage 2 combinational: magnitude add or subtract (larger operand first).
  logic        eff_sub;
  logic [11:0] mag;
  assign eff_sub = s1_sign_l_q ^ s1_sign_s_q;
  assign mag     = eff_sub ? ({1'b0, s1_sig_l_q} - {1'b0, s1_sig_s_q})
                           : ({1'b0, s1_sig_l_q} + {1'b0, s1_sig_s_q});

  logic        s2_valid_q, s2_sign_q;
  logic [7:0]  s2_exp_q;
  logic [11:0] s2_mag_q;
  logic        s2_nan_q, s2_inf_q, s2_inf_sign_q, s2_zero_both_q, s2_zero_sign_q;

  // Stage 2 register: raw magnitude, result sign and forwarded flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_q     <= 1'b0;
      s2_sign_q      <= 1'b0;
      s2_exp_q       <= 8'd0;
      s2_mag_q       <= 12'd0;
      s2_nan_q       <= 1'b0;
      s2_inf_q       <= 1'b0;
      s2_inf_sign_q  <= 1'b0;
      s2_zero_both_q <= 1'b0;
      s2_zero_sign_q <= 1'b0;
    end else if (advance) begin
      s2_valid_q     <= s1_valid_q;
      s2_sign_q      <= s1_sign_l_q;
      s2_exp_q       <= s1_exp_q;
      s2_mag_q       <= mag;
      s2_nan_q       <= s1_nan_q;
      s2_inf_q       <= s1_inf_q;
      s2_inf_sign_q  <= s1_inf_sign_q;
      s2_zero_both_q <= s1_zero_both_q;
      s2_zero_sign_q <= s1_zero_sign_q;
    end
  end

  // Stage 3 combinational: normalize, round to nearest even, pick specials.
  logic [3:0]  lzc;
  logic [10:0] norm;
  logic [9:0]  exp_n, exp_r;
  logic [8:0]  sig_r;
  logic [6:0]  mant;
  logic        round_up, exp_le0, exp_ge255;
  logic [15:0] res_d;

  always_comb begin
    lzc = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (s2_mag_q[i]) lzc = 4'(10 - i);
    end
    if (s2_mag_q[11]) begin
      norm  = {s2_mag_q[11:2], s2_mag_q[1] | s2_mag_q[0]};
      exp_n = {2'b00, s2_exp_q} + 10'd1;
    end else begin
      norm  = s2_mag_q[10:0] << lzc;
      exp_n = {2'b00, s2_exp_q} - {6'd0, lzc};
    end
    round_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    sig_r     = {1'b0, norm[10:3]} + {8'd0, round_up};
    exp_r     = sig_r[8] ? exp_n + 10'd1 : exp_n;
    mant      = sig_r[8] ? sig_r[7:1] : sig_r[6:0];
    exp_ge255 = !exp_r[9] && (exp_r >= 10'd255);
    exp_le0   = exp_r[9] || (exp_r == 10'd0);
    if (s2_nan_q) begin
      res_d = 16'h7FC0;
    end else if (s2_inf_q) begin
      res_d = {s2_inf_sign_q, 15'h7F80};
    end else if (s2_mag_q == 12'd0) begin
      // Only two signed zeros give -0; exact cancellation gives +0.
      res_d = s2_zero_both_q ? {s2_zero_sign_q, 15'd0} : 16'h0000;
    end else if (exp_ge255) begin
      res_d = {s2_sign_q, 15'h7F80};
    end else if (exp_le0) begin
      res_d = {s2_sign_q, 15'd0};
    end else begin
      res_d = {s2_sign_q, exp_r[7:0], mant};
    end
  end

  // Stage 3 register: the output itself, frozen while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      result_o    <= 16'h0000;
    end else if (advance) begin
      out_valid_o <= s2_valid_q;
      result_o    <= res_d;
    end
  end

endmodule

// File: tb/tb_bf16_add_pipe.sv
// Self-checking bench for bf16_add_pipe: directed vectors, backpressure, bubbles,
// mid-flight reset and randomized traffic against an exact-arithmetic model.
module tb_bf16_add_pipe;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] a_i = 16'h0000;
  logic [15:0] b_i = 16'h0000;
  logic        sub_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [15:0] result_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] sp [8] = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80,
                          16'h7FC1, 16'h7F7F, 16'h0080, 16'h0005};

  always #5 clk_i = ~clk_i;

  bf16_add_pipe dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .sub_i       (sub_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, want 0x%04h", tag, got, want);
    end
  endtask

  // Exact sum as a wide integer in units of 2^-133, then round to 8 significant bits.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic sub);
    logic [7:0]   ea, eb;
    logic         sa, sb, s;
    logic [271:0] va, vb, mag, rem, half, one;
    logic [8:0]   keep;
    int           p, e, sh;
    ea = a[14:7];
    eb = b[14:7];
    sa = a[15];
    sb = b[15] ^ sub;
    if ((ea == 8'hFF && a[6:0] != 0) || (eb == 8'hFF && b[6:0] != 0)) return 16'h7FC0;
    if (ea == 8'hFF && eb == 8'hFF && sa != sb) return 16'h7FC0;
    if (ea == 8'hFF) return {sa, 15'h7F80};
    if (eb == 8'hFF) return {sb, 15'h7F80};
    va = (ea == 8'd0) ? '0 : (272'({1'b1, a[6:0]}) << (ea - 8'd1));
    vb = (eb == 8'd0) ? '0 : (272'({1'b1, b[6:0]}) << (eb - 8'd1));
    if (sa == sb) begin
      mag = va + vb; s = sa;
    end else if (va >= vb) begin
      mag = va - vb; s = sa;
    end else begin
      mag = vb - va; s = sb;
    end
    if (mag == '0) return (ea == 8'd0 && eb == 8'd0) ? {sa & sb, 15'd0} : 16'h0000;
    p = 0;
    for (int i = 0; i < 272; i++) if (mag[i]) p = i;
    e = p - 6;
    if (p < 7) return {s, 15'd0};
    sh   = p - 7;
    keep = 9'(mag >> sh);
    if (sh > 0) begin
      one  = 272'(1);
      rem  = mag & ((one << sh) - one);
      half = one << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 9'd1;
    end
    if (keep == 9'd256) begin
      keep = 9'd128;
      e++;
    end
    if (e >= 255) return {s, 15'h7F80};
    if (e <= 0) return {s, 15'd0};
    return {s, 8'(e), keep[6:0]};
  endfunction

  // Scoreboard and hold-stability monitor, sampled on the falling edge.
  initial begin
    logic        prev_stall;
    logic [15:0] prev_res;
    prev_stall = 1'b0;
    prev_res   = 16'h0000;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 16'(out_valid_o), 16'd1);
          check("hold_result", result_o, prev_res);
        end
        if (in_valid_i && in_ready_o) exp_q.push_back(ref_add(a_i, b_i, sub_i));
        if (out_valid_o && out_ready_i) begin
          n_out++;
          check("queue_nonempty", 16'(exp_q.size() != 0), 16'd1);
          if (exp_q.size() != 0) check("result", result_o, exp_q.pop_front());
        end
        prev_stall = out_valid_o && !out_ready_i;
        prev_res   = result_o;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  // Issue one op, wait for its result and check latency and value.
  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic [15:0] want, input string tag);
    bit acc;
    int lat;
    in_valid_i = 1'b1;
    a_i = a;
    b_i = b;
    sub_i = sub;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk_i);
      acc = in_ready_o;
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    check({tag, "_acc"}, 16'(acc), 16'd1);
    lat = 1;
    while (!out_valid_o && lat < 10) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 16'(lat), 16'd3);
    check({tag, "_res"}, result_o, want);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [15:0] va [13] = '{16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h7F80, 16'h7F7F,
                            16'h7FC1, 16'h0001, 16'h8000, 16'h7F80, 16'hFF80, 16'h4040,
                            16'h8081};
    logic [15:0] vb [13] = '{16'h4000, 16'h3F80, 16'h3B80, 16'h3C40, 16'hFF80, 16'h7F7F,
                            16'h3F80, 16'h8000, 16'h8000, 16'h7F80, 16'h3F80, 16'h3F80,
                            16'h8080};
    logic        vs [13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                            1'b0, 1'b1, 1'b1};
    logic [15:0] vw [13] = '{16'h4040, 16'h0000, 16'h3F80, 16'h3F82, 16'h7FC0, 16'h7F80,
                            16'h7FC0, 16'h0000, 16'h8000, 16'h7FC0, 16'hFF80, 16'h4000,
                            16'h8000};
    logic [3:0]  pat;
    logic [6:0]  ov;
    int          base, seen;
    bit          acc;

    #1 rst_ni = 1'b0;
    #2;
    check("rst_valid", 16'(out_valid_o), 16'd0);
    check("rst_result", result_o, 16'h0000);
    check("rst_ready", 16'(in_ready_o), 16'd1);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    for (int i = 0; i < 13; i++) run_one(va[i], vb[i], vs[i], vw[i], $sformatf("v%0d", i));

    // Backpressure: three ops fill the pipe, the fourth must wait.
    out_ready_i = 1'b0;
    base = n_out;
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1;
      a_i = 16'h3F80;
      b_i = 16'h4000 + 16'(i * 128);
      sub_i = 1'b0;
      @(negedge clk_i);
      check("bp_ready_fill", 16'(in_ready_o), 16'd1);
      @(posedge clk_i);
      #1;
    end
    b_i = 16'h4180;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("bp_ready_full", 16'(in_ready_o), 16'd0);
      check("bp_first", result_o, 16'h4040);
    end
    @(posedge clk_i);
    #1 out_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_ready_release", 16'(in_ready_o), 16'd1);
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
    check("bp_count", 16'(n_out - base), 16'd4);
    check("bp_drained", 16'(exp_q.size()), 16'd0);

    // Bubbles: the valid pattern reappears three edges later.
    pat = 4'b1101;
    a_i = 16'h3F80;
    b_i = 16'h3F80;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk_i);
      #1 in_valid_i = (k < 4) ? pat[k] : 1'b0;
      @(negedge clk_i);
      ov[k] = out_valid_o;
    end
    for (int k = 0; k < 3; k++) check($sformatf("bub_empty%0d", k), 16'(ov[k]), 16'd0);
    for (int k = 0; k < 4; k++) check($sformatf("bub_out%0d", k), 16'(ov[k+3]), 16'(pat[k]));

    // Reset with two ops in flight, one of them already on the output.
    @(posedge clk_i);
    #1 out_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_i = 1'b1;
      a_i = 16'h4000;
      b_i = 16'h4000 + 16'(i * 128);
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    @(posedge clk_i);
    #1 check("rst_pre_valid", 16'(out_valid_o), 16'd1);
    #2 rst_ni = 1'b0;
    exp_q.delete();
    #1;
    check("rst_async_valid", 16'(out_valid_o), 16'd0);
    check("rst_async_result", result_o, 16'h0000);
    check("rst_async_ready", 16'(in_ready_o), 16'd1);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    out_ready_i = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (out_valid_o) seen++;
    end
    check("rst_no_stale", 16'(seen), 16'd0);
    @(posedge clk_i);
    #1 run_one(16'h3F80, 16'h4000, 1'b0, 16'h4040, "post_rst");

    // Random traffic with random consumer stalls; producer holds unaccepted ops.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      acc = in_valid_i && in_ready_o;
      @(posedge clk_i);
      #1;
      out_ready_i = ($urandom_range(0, 3) != 0);
      if (acc || !in_valid_i) begin
        in_valid_i = ($urandom_range(0, 3) != 0);
        a_i = 16'($urandom);
        sub_i = 1'($urandom);
        case ($urandom_range(0, 3))
          0: b_i = 16'($urandom);
          1: b_i = {1'($urandom), a_i[14:7] + 8'($urandom_range(0, 4)) - 8'd2, 7'($urandom)};
          2: begin
            b_i = sp[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 0) a_i = sp[$urandom_range(0, 7)];
          end
          default: b_i = a_i ^ 16'($urandom_range(0, 7));
        endcase
      end
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
    check("final_drained", 16'(exp_q.size()), 16'd0);
    check("final_idle", 16'(out_valid_o), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
